window_scan_sequencer: RTL and testbench

Frame-level sequencer for the sliding-window datapath: accepts a raster pixel stream and tracks row and column position. It drives line-buffer write/read enables and marks which accepted pixels complete a WIN×WIN window. Sits between the pixel source and the line buffers / window-sum stage, and presents windows downstream with a valid/ready hold. Replaces ad-hoc row/column counting inside per-stage controllers.

---
 rtl/window_pkg.sv | 30 +++
 rtl/raster_counter.sv | 52 +++++
 rtl/window_scan_sequencer.sv | 132 +++++++++++++
 tb/tb_window_scan_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared types, counter width and frame-geometry defaults for the sliding-window
// sequencer and the stages that reuse its raster counter.
package window_pkg;

    localparam int CNT_W    = 10;
    localparam int DEF_COLS = 11;
    localparam int DEF_ROWS = 11;
    localparam int DEF_WIN  = 3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // True when (row, col) can be the bottom-right corner of a win x win window.
    function automatic logic win_reach(input logic [CNT_W-1:0] row,
                                       input logic [CNT_W-1:0] col,
                                       input int               win);
        logic [CNT_W-1:0] lim;
        lim       = CNT_W'(win - 1);
        win_reach = (row >= lim) && (col >= lim);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Wrapping column/row counter pair for raster-ordered streams; advances one
// position per increment and wraps to (0,0) after the last pixel of a frame.
module raster_counter
    import window_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             col_last,
    output logic             row_last
);

    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(ROWS - 1);

    logic [CNT_W-1:0] col_r;
    logic [CNT_W-1:0] row_r;

    assign col      = col_r;
    assign row      = row_r;
    assign col_last = (col_r == COL_MAX);
    assign row_last = (row_r == ROW_MAX);

    // Position register: clear has priority, row steps only on column wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r <= CNT_ZERO;
            row_r <= CNT_ZERO;
        end else if (clr) begin
            col_r <= CNT_ZERO;
            row_r <= CNT_ZERO;
        end else if (inc) begin
            if (col_last) begin
                col_r <= CNT_ZERO;
                if (row_last) begin
                    row_r <= CNT_ZERO;
                end else begin
                    row_r <= row_r + CNT_ONE;
                end
            end else begin
                col_r <= col_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/window_scan_sequencer.sv
// Frame sequencer for the sliding-window datapath: tracks raster position, drives
// line-buffer enables and presents completed windows with a valid/ready hold.
module window_scan_sequencer
    import window_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int WIN  = DEF_WIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col,
    output logic             lb_wr_en,
    output logic             lb_rd_en,
    output logic [CNT_W-1:0] lb_addr,
    output logic             row_start,
    output logic             row_last,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] FILL_LAST_ROW = CNT_W'(WIN - 2);

    seq_state_e       state_r;
    logic [CNT_W-1:0] col_cnt_s;
    logic [CNT_W-1:0] row_cnt_s;
    logic             col_last_s;
    logic             row_last_s;
    logic             stall_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             hit_s;
    logic             clr_s;
    logic             out_valid_r;
    logic [CNT_W-1:0] out_row_r;
    logic [CNT_W-1:0] out_col_r;
    logic             frame_done_r;

    raster_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .inc      (accept_s),
        .col      (col_cnt_s),
        .row      (row_cnt_s),
        .col_last (col_last_s),
        .row_last (row_last_s)
    );

    // A held window that downstream has not taken blocks new pixels, so no hit is lost.
    assign stall_s    = out_valid_r && !out_ready;
    assign in_ready_s = ((state_r == FILL) || (state_r == RUN)) && !stall_s;
    assign accept_s   = in_valid && in_ready_s;
    assign hit_s      = accept_s && (state_r == RUN) && win_reach(row_cnt_s, col_cnt_s, WIN);
    assign clr_s      = (state_r == IDLE) && start;

    assign in_ready   = in_ready_s;
    assign lb_wr_en   = accept_s;
    assign lb_rd_en   = accept_s && (row_cnt_s >= CNT_ONE);
    assign lb_addr    = col_cnt_s;
    assign row_start  = accept_s && (col_cnt_s == CNT_ZERO);
    assign row_last   = accept_s && col_last_s;
    assign busy       = (state_r != IDLE);
    assign out_valid  = out_valid_r;
    assign out_row    = out_row_r;
    assign out_col    = out_col_r;
    assign frame_done = frame_done_r;

    // Frame phase tracking and the one-cycle end-of-frame pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= FILL;
                    end
                end
                FILL: begin
                    if (accept_s && col_last_s && (row_cnt_s == FILL_LAST_ROW)) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (accept_s && col_last_s && row_last_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!out_valid_r || out_ready) begin
                        state_r      <= DONE;
                        frame_done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Window presentation register: a fresh hit wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_row_r   <= CNT_ZERO;
            out_col_r   <= CNT_ZERO;
        end else if (hit_s) begin
            out_valid_r <= 1'b1;
            out_row_r   <= row_cnt_s;
            out_col_r   <= col_cnt_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_scan_sequencer.sv
// Scoreboard bench: stimulus pushes expected windows, per-instance monitors pop on handshake.
module tb_window_scan_sequencer;
    import window_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, in_valid_a, out_ready_a;
    logic       in_ready_a, out_valid_a, lb_wr_en_a, lb_rd_en_a, row_start_a, row_last_a, busy_a, frame_done_a;
    logic [9:0] out_row_a, out_col_a, lb_addr_a;
    logic       rst_b, start_b, in_valid_b, out_ready_b;
    logic       in_ready_b, out_valid_b, lb_wr_en_b, lb_rd_en_b, row_start_b, row_last_b, busy_b, frame_done_b;
    logic [9:0] out_row_b, out_col_b, lb_addr_b;

    window_scan_sequencer dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_ready(out_ready_a), .out_valid(out_valid_a), .out_row(out_row_a), .out_col(out_col_a),
        .lb_wr_en(lb_wr_en_a), .lb_rd_en(lb_rd_en_a), .lb_addr(lb_addr_a), .row_start(row_start_a),
        .row_last(row_last_a), .busy(busy_a), .frame_done(frame_done_a)
    );

    window_scan_sequencer #(.COLS(4), .ROWS(2), .WIN(2)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_ready(out_ready_b), .out_valid(out_valid_b), .out_row(out_row_b), .out_col(out_col_b),
        .lb_wr_en(lb_wr_en_b), .lb_rd_en(lb_rd_en_b), .lb_addr(lb_addr_b), .row_start(row_start_b),
        .row_last(row_last_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    logic [19:0] exp_a_q[$];
    logic [19:0] exp_b_q[$];
    int beats_a = 0, beats_b = 0, fd_a = 0, fd_b = 0, fd_cyc_a = 0, fd_cyc_b = 0;
    logic [19:0] first_a, last_a;
    logic [19:0] b_tbl [3] = '{{10'd1, 10'd1}, {10'd1, 10'd2}, {10'd1, 10'd3}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard monitor for the default-geometry instance.
    always begin : mon_a
        logic [19:0] e;
        @(negedge clk);
        #4;
        if (rst_a && out_valid_a && out_ready_a) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_window", 1, 0);
            end else begin
                e = exp_a_q.pop_front();
                check("a_win_row", int'(out_row_a), int'(e[19:10]));
                check("a_win_col", int'(out_col_a), int'(e[9:0]));
            end
            if (beats_a == 0) first_a = {out_row_a, out_col_a};
            last_a = {out_row_a, out_col_a};
            beats_a++;
        end
        if (frame_done_a) begin
            fd_a++;
            fd_cyc_a = cyc;
        end
    end

    // Scoreboard monitor for the small-geometry instance.
    always begin : mon_b
        logic [19:0] e;
        @(negedge clk);
        #4;
        if (rst_b && out_valid_b && out_ready_b) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_window", 1, 0);
            end else begin
                e = exp_b_q.pop_front();
                check("b_win_row", int'(out_row_b), int'(e[19:10]));
                check("b_win_col", int'(out_col_b), int'(e[9:0]));
            end
            beats_b++;
        end
        if (frame_done_b) begin
            fd_b++;
            fd_cyc_b = cyc;
        end
    end

    // mode 0 streaming, 1 in_valid toggling, 2 downstream stall, 3 start in RUN, 4 reset at (5,4)
    task automatic run_a(input int mode);
        int acc_n, row_m, col_m, guard, stall_left, last_cyc, fd0;
        bit hit_seen, tog, aborted;
        logic acc;
        acc_n = 0; row_m = 0; col_m = 0; guard = 0; stall_left = 0; last_cyc = 0;
        hit_seen = 1'b0; tog = 1'b1; aborted = 1'b0;
        fd0 = fd_a;
        beats_a = 0;
        @(negedge clk); #1;
        start_a = 1'b1;
        @(negedge clk); #1;
        while (acc_n < 121 && guard < 2000) begin
            in_valid_a  = (mode == 1) ? tog : 1'b1;
            tog         = !tog;
            out_ready_a = (stall_left > 0) ? 1'b0 : 1'b1;
            start_a     = (mode == 3 && row_m == 5 && col_m == 0) ? 1'b1 : 1'b0;
            if (mode == 4 && row_m == 5 && col_m == 4) begin
                aborted = 1'b1;
                break;
            end
            #1;
            acc = in_valid_a && in_ready_a;
            if (stall_left > 0) begin
                check("a_stall_in_ready", int'(in_ready_a), 0);
                check("a_stall_no_accept", int'(acc), 0);
                check("a_stall_hold_row", int'(out_row_a), 2);
                check("a_stall_hold_col", int'(out_col_a), 2);
                stall_left--;
            end
            if (start_a) check("a_busy_on_start", int'(busy_a), 1);
            if (acc) begin
                check("a_wr_en", int'(lb_wr_en_a), 1);
                check("a_lb_addr", int'(lb_addr_a), col_m);
                check("a_rd_en", int'(lb_rd_en_a), int'(row_m >= 1));
                check("a_row_start", int'(row_start_a), int'(col_m == 0));
                check("a_row_last", int'(row_last_a), int'(col_m == 10));
                if (row_m >= 2 && col_m >= 2) begin
                    exp_a_q.push_back({10'(row_m), 10'(col_m)});
                    if (mode == 2 && !hit_seen) stall_left = 5;
                    hit_seen = 1'b1;
                end
                last_cyc = cyc;
                acc_n++;
                if (col_m == 10) begin
                    col_m = 0;
                    row_m++;
                end else begin
                    col_m++;
                end
            end else begin
                check("a_no_wr_without_accept", int'(lb_wr_en_a), 0);
            end
            guard++;
            @(negedge clk); #1;
        end
        in_valid_a = 1'b0;
        start_a    = 1'b0;
        if (aborted) begin
            rst_a = 1'b0;
            #1;
            check("a_rst_out_valid", int'(out_valid_a), 0);
            check("a_rst_busy", int'(busy_a), 0);
            check("a_rst_in_ready", int'(in_ready_a), 0);
            check("a_rst_lb_addr", int'(lb_addr_a), 0);
            check("a_rst_out_row", int'(out_row_a), 0);
            check("a_rst_out_col", int'(out_col_a), 0);
            exp_a_q.delete();
            @(negedge clk); #1;
            rst_a = 1'b1;
            repeat (5) @(negedge clk);
            #1;
            check("a_rst_no_frame_done", fd_a - fd0, 0);
            check("a_rst_idle", int'(busy_a), 0);
        end else begin
            check("a_accept_budget", acc_n, 121);
            guard = 0;
            while (fd_a == fd0 && guard < 20) begin
                @(negedge clk); #1;
                guard++;
            end
            repeat (3) @(negedge clk);
            #1;
            check("a_frame_done_count", fd_a - fd0, 1);
            check("a_frame_done_latency", fd_cyc_a - last_cyc, 2);
            check("a_beats", beats_a, 81);
            check("a_queue_empty", exp_a_q.size(), 0);
            check("a_first_row", int'(first_a[19:10]), 2);
            check("a_first_col", int'(first_a[9:0]), 2);
            check("a_last_row", int'(last_a[19:10]), 10);
            check("a_last_col", int'(last_a[9:0]), 10);
            check("a_idle_after_frame", int'(busy_a), 0);
        end
    endtask

    task automatic run_b();
        int acc_n, row_m, col_m, guard, hit_idx, fd0;
        logic acc;
        acc_n = 0; row_m = 0; col_m = 0; guard = 0; hit_idx = 0;
        fd0 = fd_b;
        beats_b = 0;
        @(negedge clk); #1;
        start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        while (acc_n < 8 && guard < 200) begin
            in_valid_b = 1'b1;
            #1;
            acc = in_valid_b && in_ready_b;
            if (acc) begin
                check("b_state", int'(dut_b.state_r), (acc_n < 4) ? int'(FILL) : int'(RUN));
                check("b_rd_en", int'(lb_rd_en_b), int'(row_m >= 1));
                check("b_lb_addr", int'(lb_addr_b), col_m);
                if (row_m >= 1 && col_m >= 1) begin
                    if (hit_idx < 3) exp_b_q.push_back(b_tbl[hit_idx]);
                    else check("b_extra_hit", hit_idx, 2);
                    hit_idx++;
                end
                acc_n++;
                if (col_m == 3) begin
                    col_m = 0;
                    row_m++;
                end else begin
                    col_m++;
                end
            end
            guard++;
            @(negedge clk); #1;
        end
        in_valid_b = 1'b0;
        guard = 0;
        while (fd_b == fd0 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("b_accepts", acc_n, 8);
        check("b_beats", beats_b, 3);
        check("b_frame_done_count", fd_b - fd0, 1);
        check("b_queue_empty", exp_b_q.size(), 0);
    endtask

    initial begin
        rst_a = 1'b0; start_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        rst_b = 1'b0; start_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", int'(out_valid_a), 0);
        check("reset_busy", int'(busy_a), 0);
        check("reset_in_ready", int'(in_ready_a), 0);
        check("reset_lb_addr", int'(lb_addr_a), 0);
        check("reset_frame_done", int'(frame_done_a), 0);
        check("reset_out_row", int'(out_row_a), 0);
        check("reset_b_out_valid", int'(out_valid_b), 0);
        @(negedge clk); #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        run_a(0);
        run_a(0);
        run_a(1);
        run_a(2);
        run_a(3);
        run_a(4);
        run_a(0);
        run_b();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
